// File: rtl/mux3_rr_arbiter_pkg.sv
// Shared definitions for the three-requester round-robin bus arbiter:
// state encoding, select codes and small index helpers.
package mux3_rr_arbiter_pkg;

   localparam int NUM_REQ = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arbState_t;

   localparam logic [1:0] SEL_R0 = 2'b00;
   localparam logic [1:0] SEL_R1 = 2'b01;
   localparam logic [1:0] SEL_R2 = 2'b10;

   // Reduces a small sum (0..5) modulo 3.
   function automatic logic [1:0] wrap3(input logic [2:0] v);
      if (v >= 3'd3) begin
         return 2'(v - 3'd3);
      end
      return v[1:0];
   endfunction

   function automatic logic [1:0] oneHotToSel(input logic [NUM_REQ-1:0] oh);
      if (oh[2]) begin
         return SEL_R2;
      end
      if (oh[1]) begin
         return SEL_R1;
      end
      return SEL_R0;
   endfunction

endpackage

// File: rtl/mux3_rr_arbiter_pick.sv
// rr_pick3: combinational round-robin picker. The search starts at iPtr and
// wraps; oWin is the one-hot winner, oValid flags that anyone was asking.
module rr_pick3
   import mux3_rr_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] iReq,
   input  logic [1:0]         iPtr,
   output logic [NUM_REQ-1:0] oWin,
   output logic               oValid
);

   logic [NUM_REQ-1:0] rotReq;
   logic [NUM_REQ-1:0] rotWin;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : gRotate
         logic [1:0] srcIdx;
         logic [1:0] posIdx;
         // srcIdx: requester looked at in search slot gi; posIdx: slot holding requester gi
         assign srcIdx     = wrap3({1'b0, iPtr} + 3'(gi));
         assign posIdx     = wrap3(3'(gi) + 3'd3 - {1'b0, iPtr});
         assign rotReq[gi] = iReq[srcIdx];
         assign oWin[gi]   = rotWin[posIdx];
      end
   endgenerate

   assign rotWin[0] = rotReq[0];
   assign rotWin[1] = rotReq[1] & ~rotReq[0];
   assign rotWin[2] = rotReq[2] & ~(|rotReq[1:0]);
   assign oValid    = |iReq;

endmodule

// File: rtl/mux3_rr_arbiter.sv
// Three-requester round-robin bus arbiter with registered grant and a
// combinational data mux. Define MUX3_ARB_TIMEOUT_EN to bound grant tenure.
module mux3_rr_arbiter
   import mux3_rr_arbiter_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic               iClk,
   input  logic               iRst_n,
   input  logic [2:0]         iReq,
   input  logic [WIDTH-1:0]   iData0,
   input  logic [WIDTH-1:0]   iData1,
   input  logic [WIDTH-1:0]   iData2,
   output logic [2:0]         oGnt,
   output logic [1:0]         oS,
   output logic [WIDTH-1:0]   oData,
   output logic               oBusy,
   output logic               oTimeout
);

   arbState_t  stateReg, stateNext;
   logic [2:0] gntReg, gntNext;
   logic [1:0] selReg, selNext;
   logic [1:0] ptrReg, ptrNext;
   logic       busyReg;

   logic [2:0] pickReq;
   logic [2:0] pickWin;
   logic [1:0] pickPtr;
   logic       pickValid;
   logic       ownerReq;
   logic       timeoutHit;
   logic       doRelease;
   logic       newGrant;

   assign ownerReq = |(iReq & gntReg);

   // On release the owner is masked out and the search starts just after it.
   assign pickReq   = (stateReg == BUSY) ? (iReq & ~gntReg) : iReq;
   assign pickPtr   = (stateReg == BUSY) ? wrap3({1'b0, selReg} + 3'd1) : ptrReg;
   assign doRelease = (stateReg == BUSY) && (!ownerReq || timeoutHit);

   rr_pick3 uPick (
      .iReq   (pickReq),
      .iPtr   (pickPtr),
      .oWin   (pickWin),
      .oValid (pickValid)
   );

   always_comb begin
      stateNext = stateReg;
      gntNext   = gntReg;
      selNext   = selReg;
      ptrNext   = ptrReg;
      newGrant  = 1'b0;
      if (stateReg == IDLE || doRelease) begin
         if (doRelease) begin
            ptrNext = pickPtr;
         end
         if (pickValid) begin
            stateNext = BUSY;
            gntNext   = pickWin;
            selNext   = oneHotToSel(pickWin);
            newGrant  = 1'b1;
         end else begin
            stateNext = IDLE;
            gntNext   = '0;
            selNext   = SEL_R0;
         end
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         stateReg <= IDLE;
         gntReg   <= '0;
         selReg   <= SEL_R0;
         ptrReg   <= 2'd0;
         busyReg  <= 1'b0;
      end else begin
         stateReg <= stateNext;
         gntReg   <= gntNext;
         selReg   <= selNext;
         ptrReg   <= ptrNext;
         busyReg  <= |gntNext;
      end
   end

`ifdef MUX3_ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cntReg, cntNext;
   logic          timeoutReg;

   assign timeoutHit = ownerReq && (cntReg == CW'(TIMEOUT - 1));

   always_comb begin
      cntNext = cntReg;
      if (newGrant) begin
         cntNext = '0;
      end else if (stateReg == BUSY) begin
         cntNext = cntReg + 1'b1;
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         cntReg     <= '0;
         timeoutReg <= 1'b0;
      end else begin
         cntReg     <= cntNext;
         timeoutReg <= doRelease && timeoutHit;
      end
   end

   assign oTimeout = timeoutReg;
`else
   assign timeoutHit = 1'b0;
   assign oTimeout   = 1'b0;
`endif

   always_comb begin
      case (selReg)
         SEL_R1:  oData = iData1;
         SEL_R2:  oData = iData2;
         default: oData = iData0;
      endcase
   end

   assign oGnt  = gntReg;
   assign oS    = selReg;
   assign oBusy = busyReg;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Self-checking bench for mux3_rr_arbiter: directed scenarios plus random
// request traffic compared against an owner/pointer reference model.
module tb_mux3_rr_arbiter;

   localparam int W  = 8;
   localparam int TO = 4;
`ifdef MUX3_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic         iClk   = 1'b0;
   logic         iRst_n = 1'b0;
   logic [2:0]   iReq   = 3'b000;
   logic [W-1:0] iData0 = '0;
   logic [W-1:0] iData1 = '0;
   logic [W-1:0] iData2 = '0;
   logic [2:0]   oGnt;
   logic [1:0]   oS;
   logic [W-1:0] oData;
   logic         oBusy;
   logic         oTimeout;

   mux3_rr_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .iClk     (iClk),
      .iRst_n   (iRst_n),
      .iReq     (iReq),
      .iData0   (iData0),
      .iData1   (iData1),
      .iData2   (iData2),
      .oGnt     (oGnt),
      .oS       (oS),
      .oData    (oData),
      .oBusy    (oBusy),
      .oTimeout (oTimeout)
   );

   always #5 iClk = ~iClk;

   int total = 0;
   int bad   = 0;

   // Reference model: who owns the bus (-1 = nobody), where the search
   // starts next, how many BUSY cycles have elapsed in this tenure.
   int mOwner = -1;
   int mPtr   = 0;
   int mTen   = 0;
   bit mTout  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic mReset();
      mOwner = -1;
      mPtr   = 0;
      mTen   = 0;
      mTout  = 1'b0;
   endtask

   // Advance the model by one rising edge using the request vector seen there.
   task automatic modelStep();
      bit ownerHigh;
      bit expire;
      int old;
      int idx;
      mTout = 1'b0;
      if (mOwner < 0) begin
         for (int k = 0; k < 3; k++) begin
            idx = (mPtr + k) % 3;
            if (mOwner < 0 && iReq[idx]) mOwner = idx;
         end
         mTen = 0;
      end else begin
         ownerHigh = iReq[mOwner];
         expire    = TO_EN && ownerHigh && (mTen == TO - 1);
         if (!ownerHigh || expire) begin
            old    = mOwner;
            mPtr   = (old + 1) % 3;
            mOwner = -1;
            for (int k = 0; k < 3; k++) begin
               idx = (mPtr + k) % 3;
               if (mOwner < 0 && idx != old && iReq[idx]) mOwner = idx;
            end
            mTen  = 0;
            mTout = expire;
         end else begin
            mTen++;
         end
      end
   endtask

   task automatic checkOutputs(input string tag);
      logic [2:0]   expGnt;
      logic [1:0]   expS;
      logic [W-1:0] expData;
      expGnt  = (mOwner < 0) ? 3'b000 : 3'(1 << mOwner);
      expS    = (mOwner < 0) ? 2'd0 : 2'(mOwner);
      expData = (expS == 2'd1) ? iData1 : (expS == 2'd2) ? iData2 : iData0;
      check({tag, "_gnt"},  oGnt,     expGnt);
      check({tag, "_s"},    oS,       expS);
      check({tag, "_busy"}, oBusy,    (mOwner >= 0));
      check({tag, "_tout"}, oTimeout, mTout);
      check({tag, "_data"}, oData,    expData);
   endtask

   task automatic step(input logic [2:0] req, input string tag);
      @(negedge iClk);
      iReq   = req;
      iData0 = W'($urandom);
      iData1 = W'($urandom);
      iData2 = W'($urandom);
      @(posedge iClk);
      modelStep();
      #1;
      checkOutputs(tag);
   endtask

   task automatic doReset();
      @(negedge iClk);
      iRst_n = 1'b0;
      iReq   = 3'b000;
      #1;
      mReset();
      checkOutputs("rst");
      @(negedge iClk);
      iRst_n = 1'b1;
   endtask

   initial begin
      logic [2:0] r;

      // Reset state
      #2;
      checkOutputs("rst_init");
      doReset();

      // Single request: grant one cycle later
      step(3'b001, "r37");
      check("r37_gnt_const", oGnt, 3'b001);
      check("r37_data_eq",   oData, iData0);
      step(3'b000, "r37_drop");

      // All requesting: 0,1,2,0 back-to-back
      doReset();
      step(3'b111, "r38_a");
      check("r38_first", oGnt, 3'b001);
      step(3'b110, "r38_b");
      check("r38_second", oGnt, 3'b010);
      step(3'b101, "r38_c");
      check("r38_third", oGnt, 3'b100);
      step(3'b011, "r38_d");
      check("r38_fourth", oGnt, 3'b001);
      check("r38_nogap", oBusy, 1'b1);

      // No preemption of requester 1
      doReset();
      step(3'b010, "r39_a");
      for (int i = 0; i < 3; i++) step(3'b111, "r39_hold");
      check("r39_hold_gnt", oGnt, 3'b010);
      step(3'b101, "r39_next");
      check("r39_next_gnt", oGnt, 3'b100);

      // Asynchronous reset mid-tenure
      doReset();
      step(3'b001, "r40_a");
      step(3'b001, "r40_b");
      @(posedge iClk);
      modelStep();
      #3;
      iRst_n = 1'b0;
      #1;
      mReset();
      checkOutputs("r40_async");
      check("r40_async_gnt", oGnt, 3'b000);
      @(negedge iClk);
      iRst_n = 1'b1;
      step(3'b110, "r40_after");
      check("r40_after_gnt", oGnt, 3'b010);

      // Tenure bound
      doReset();
      step(3'b011, "r4x_grant");
`ifdef MUX3_ARB_TIMEOUT_EN
      for (int i = 0; i < TO - 1; i++) step(3'b011, "r41_hold");
      check("r41_still0", oGnt, 3'b001);
      step(3'b011, "r41_expire");
      check("r41_tout_pulse", oTimeout, 1'b1);
      check("r41_gnt1", oGnt, 3'b010);
      step(3'b011, "r41_after");
      check("r41_tout_low", oTimeout, 1'b0);
`else
      for (int i = 0; i < 100; i++) step(3'b001, "r42_hold");
      check("r42_gnt", oGnt, 3'b001);
      check("r42_tout", oTimeout, 1'b0);
`endif

      // Random traffic: owner holds with high probability, others toggle freely
      doReset();
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < 3; k++) begin
            r[k] = (k == mOwner) ? ($urandom_range(0, 4) != 0) : 1'($urandom_range(0, 1));
         end
         step(r, "rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux3_rr_arbiter.md
MUX3_RR_ARBITER -- requirements
Module: mux3_rr_arbiter

Interface
REQ-001 The block SHALL have parameter `WIDTH`, default 32: data width of each requester's bus.
REQ-002 The block SHALL have parameter `TIMEOUT`, default 16: maximum grant tenure in cycles, used only with the configuration macro.
REQ-003 The block SHALL have port `iClk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port `iRst_n`: input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port `iReq`: input, 3 bits; bit k is requester k asking for the shared bus, held high for the whole tenure.
REQ-006 The block SHALL have ports `iData0`, `iData1`, `iData2`: input, `WIDTH` bits each; requester data.
REQ-007 The block SHALL have port `oGnt`: output, 3 bits, one-hot or zero; the current owner.
REQ-008 The block SHALL have port `oS`: output, 2 bits; the select code, 00/01/10 for requester 0/1/2.
REQ-009 The block SHALL have port `oData`: output, `WIDTH` bits; the selected requester's data.
REQ-010 The block SHALL have port `oBusy`: output, 1 bit; high while any grant is held.
REQ-011 The block SHALL have port `oTimeout`: output, 1 bit; a one-cycle pulse on forced release.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-013 In IDLE, a nonzero `iReq` SHALL move the FSM to BUSY at the next edge, granting the winner; grant latency is 1 cycle from request.
REQ-014 The winner SHALL be picked round-robin: search order starts at `ptr`, then `ptr+1` mod 3, then `ptr+2` mod 3.
REQ-015 In BUSY, the grant SHALL hold while the owner's `iReq` bit stays high; other requests are ignored (no preemption).
REQ-016 When the owner drops `iReq`, `ptr` SHALL become owner+1 mod 3 at the next edge.
REQ-017 At that same edge, if any other request is high, it SHALL be granted directly (back-to-back, no idle cycle, stays BUSY); otherwise the FSM SHALL go to IDLE.
REQ-018 The owner SHALL re-request only after a drop of at least one cycle.
REQ-019 All outputs except `oData` SHALL be registered.
REQ-020 `oData` SHALL be combinational from `oS`: `iData0`, `iData1` or `iData2` for 00, 01, 10.
REQ-021 When `oGnt` is 000, `oS` SHALL be 00 and `oData` SHALL be `iData0`.
REQ-022 `oS` code 11 SHALL never be produced.
REQ-023 `oBusy` SHALL equal |`oGnt`, and `oGnt` SHALL be consistent with `oS` in every cycle.
REQ-024 Simultaneous requests SHALL be resolved only by `ptr`.
REQ-025 An `iReq` bit toggled while not owned SHALL have no effect until arbitration.

Reset
REQ-026 While `iRst_n` is low, the block SHALL hold: state IDLE, `oGnt` 000, `oS` 00, `oBusy` 0, `oTimeout` 0, `ptr` 0, tenure counter 0.
REQ-027 Assertion of `iRst_n` SHALL take effect immediately, including mid-tenure.
REQ-028 After deassertion, the first arbitration SHALL occur at the first rising edge with `iRst_n` high.

Configuration
REQ-029 With macro `MUX3_ARB_TIMEOUT_EN` defined, a tenure counter SHALL reset on every new grant and increment each BUSY cycle.
REQ-030 With `MUX3_ARB_TIMEOUT_EN`, when the counter reaches `TIMEOUT`-1 with the owner's request still high, the grant SHALL be released at the next edge.
REQ-031 On that forced release, `oTimeout` SHALL pulse for 1 cycle, `ptr` SHALL be set to owner+1, and other pending requests SHALL be granted as in REQ-017.
REQ-032 On that forced release, the timed-out requester SHALL be re-grantable only when it is next in round-robin order.
REQ-033 Without `MUX3_ARB_TIMEOUT_EN`, no counter SHALL exist, `oTimeout` SHALL be tied 0, and tenure SHALL be unbounded.

Structure
REQ-034 A shared package SHALL hold the state encoding (IDLE, BUSY), the select codes `SEL_R0`=00, `SEL_R1`=01 and `SEL_R2`=10, and the requester count 3.
REQ-035 The block SHALL contain one sub-module, `rr_pick3`: a combinational round-robin picker whose inputs are `iReq` and `ptr` and whose outputs are the one-hot winner and the valid flag.
REQ-036 The FSM, pointer, counter and output mux SHALL live in `mux3_rr_arbiter`.

Verification
REQ-037 Reset, then `iReq`=001 at cycle 1 -> `oGnt`=001, `oS`=00 and `oBusy`=1 at cycle 2; `oData` equals `iData0`.
REQ-038 `iReq`=111 from reset -> grant order 0, 1, 2, 0 as each owner drops its request for 1 cycle; no idle cycle between grants.
REQ-039 Owner 1 holds and `iReq` becomes 111 -> `oGnt` stays 010 until bit 1 falls; requester 2 is granted next.
REQ-040 `iRst_n` is pulsed low mid-tenure, asynchronous to `iClk` -> outputs go to their reset values immediately; after release, `ptr`=0 and `iReq`=110 grants requester 1.
REQ-041 With `MUX3_ARB_TIMEOUT_EN` and `TIMEOUT`=4, requester 0 holds with `iReq`=011 -> release after 4 BUSY cycles, a one-cycle `oTimeout` pulse, and `oGnt`=010 next.
REQ-042 Without the macro, requester 0 holds for 100 cycles -> `oGnt` stays 001 and `oTimeout` stays 0.
